// File: rtl/mux_reg_n.sv
`default_nettype none
// ============================================================================
//  Module      : mux_reg_n
//  Description : Registered N:1 multiplexer with a configurable pipeline
//                depth, stall (enable), synchronous flush and a sticky
//                illegal-select flag. A valid bit travels with each word.
//                Compile-time option MUX_REG_N_ONEHOT_EN switches the
//                select from SEL_W-bit binary to NUM_IN-bit one-hot.
//  Revision    : 1.0 - initial release, successor of the 2:1 address mux
// ============================================================================
module mux_reg_n #(
    parameter int               WIDTH     = 32,
    parameter int               NUM_IN    = 4,
    parameter int               SEL_W     = 2,
    parameter int               STAGES    = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     flush,
`ifdef MUX_REG_N_ONEHOT_EN
    input  logic [NUM_IN-1:0]        control,
`else
    input  logic [SEL_W-1:0]         control,
`endif
    input  logic                     valid_in,
    input  logic [NUM_IN*WIDTH-1:0]  dados_in,
    output logic [WIDTH-1:0]         saida,
    output logic                     valid_out,
    output logic                     erro_sel
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity checks
    // ------------------------------------------------------------------
    if (NUM_IN < 2 || NUM_IN > 16) begin : g_chk_num_in
        $error("mux_reg_n: NUM_IN must lie in 2..16");
    end
    if (STAGES < 1 || STAGES > 4) begin : g_chk_stages
        $error("mux_reg_n: STAGES must lie in 1..4");
    end
    if (SEL_W < 1) begin : g_chk_sel_w
        $error("mux_reg_n: SEL_W must be at least 1");
    end
`ifndef MUX_REG_N_ONEHOT_EN
    if ((2 ** SEL_W) < NUM_IN) begin : g_chk_sel_range
        $error("mux_reg_n: SEL_W too narrow to address NUM_IN channels");
    end
`endif

    // ------------------------------------------------------------------
    // Input channel unpacking: channel k lives at [k*WIDTH +: WIDTH]
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_chan [NUM_IN];

    for (genvar k = 0; k < NUM_IN; k++) begin : g_chan
        assign w_chan[k] = dados_in[k*WIDTH +: WIDTH];
    end

    // ------------------------------------------------------------------
    // Select decode. An illegal select falls back to channel 0 so the
    // datapath always carries a defined word; w_sel_legal drives the flag.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_sel_word;
    logic             w_sel_legal;

`ifdef MUX_REG_N_ONEHOT_EN
    logic             w_hot_nonzero;
    logic             w_hot_single;

    // One-hot decode: AND-OR of the channels, legal only with exactly one bit set
    always_comb begin
        w_hot_nonzero = (control != '0);
        w_hot_single  = ((control & (control - NUM_IN'(1))) == '0);
        w_sel_legal   = w_hot_nonzero && w_hot_single;
        w_sel_word    = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (control[k]) begin
                w_sel_word = w_sel_word | w_chan[k];
            end
        end
        // Zero-hot or multi-hot selects must not merge channels
        if (!w_sel_legal) begin
            w_sel_word = w_chan[0];
        end
    end
`else
    // Binary decode: codes at or above NUM_IN match no channel and stay illegal
    always_comb begin
        w_sel_legal = 1'b0;
        w_sel_word  = w_chan[0];
        for (int k = 0; k < NUM_IN; k++) begin
            if (control == SEL_W'(k)) begin
                w_sel_legal = 1'b1;
                w_sel_word  = w_chan[k];
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // Pipeline storage. Index 0 is the capture stage, STAGES-1 drives the
    // outputs. Priority at each edge: flush, then stall, then advance.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]  r_data [STAGES];
    logic [STAGES-1:0] r_valid;

    // Data/valid pipeline: async reset and flush clear, enable shifts by one
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                r_data[i] <= RESET_VAL;
            end
            r_valid <= '0;
        end else if (flush) begin
            for (int i = 0; i < STAGES; i++) begin
                r_data[i] <= RESET_VAL;
            end
            r_valid <= '0;
        end else if (enable) begin
            r_data[0]  <= w_sel_word;
            r_valid[0] <= valid_in;
            for (int i = 1; i < STAGES; i++) begin
                r_data[i]  <= r_data[i-1];
                r_valid[i] <= r_valid[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky illegal-select flag. Only a qualified (valid_in) word on an
    // advancing edge can set it; flush beats a simultaneous illegal select.
    // ------------------------------------------------------------------
    logic r_erro_sel;

    // Error flag: set on a valid illegal capture, cleared only by reset/flush
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_erro_sel <= 1'b0;
        end else if (flush) begin
            r_erro_sel <= 1'b0;
        end else if (enable && valid_in && !w_sel_legal) begin
            r_erro_sel <= 1'b1;
        end
    end

    assign saida     = r_data[STAGES-1];
    assign valid_out = r_valid[STAGES-1];
    assign erro_sel  = r_erro_sel;

endmodule
`default_nettype wire
